// File: rtl/redmule_job_ctrl.sv
// Job/context controller for the RedMulE engine: N shadow configuration contexts,
// acquire/program/trigger from software, FIFO dispatch with a start/done handshake.
module redmule_job_ctrl #(
    parameter int N_CONTEXT = 2,
    parameter int N_REGS    = 22,
    parameter int ID_W      = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cfg_we_i,
    input  logic                 cfg_re_i,
    input  logic [7:0]           cfg_addr_i,
    input  logic [31:0]          cfg_wdata_i,
    output logic [31:0]          cfg_rdata_o,
    output logic                 start_o,
    output logic [N_REGS*32-1:0] cfg_o,
    input  logic                 done_i,
    output logic                 evt_o,
    output logic                 busy_o
);
    localparam int PTR_W = $clog2(N_CONTEXT);
    localparam int CNT_W = $clog2(N_CONTEXT + 1);
    localparam int IDX_W = $clog2(N_REGS);
    localparam logic [CNT_W-1:0] N_CTX_C  = CNT_W'(N_CONTEXT);
    localparam logic [4:0]       N_REGS_C = 5'(N_REGS);

    typedef enum logic [1:0] {IDLE, START, RUN} state_t;

    state_t             state_reg, state_next;
    logic [31:0]        ctx_mem [N_CONTEXT][N_REGS];
    logic [ID_W-1:0]    tag_mem [N_CONTEXT];
    logic [31:0]        cfg_reg [N_REGS];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]   queued_reg;
    logic               acquired_reg;
    logic [ID_W-1:0]    job_id_reg, running_id_reg;
    logic [31:0]        finished_reg;
    logic               evt_reg;

    logic               ctrl_sel;
    logic [2:0]         ctrl_idx;
    logic [4:0]         reg_idx_full;
    logic [IDX_W-1:0]   reg_idx;
    logic               reg_in_range;
    logic               soft_clear, clear, trigger, reg_we, acq_ok, dispatch, finish;
    logic [CNT_W-1:0]   occupied, free_cnt;
    logic [31:0]        status;
    logic               addr_unused;

    assign ctrl_sel     = cfg_addr_i[7];
    assign ctrl_idx     = cfg_addr_i[2:0];
    assign reg_idx_full = cfg_addr_i[4:0];
    assign reg_idx      = reg_idx_full[IDX_W-1:0];
    assign reg_in_range = reg_idx_full < N_REGS_C;
    assign addr_unused  = ^cfg_addr_i[6:5];

    assign soft_clear = cfg_we_i && ctrl_sel && (ctrl_idx == 3'd5);
    assign clear      = rst_i || soft_clear;
    assign trigger    = cfg_we_i && ctrl_sel && (ctrl_idx == 3'd0) && acquired_reg;
    assign reg_we     = cfg_we_i && !ctrl_sel && reg_in_range && acquired_reg;

    // The dispatched job stays in queued_reg during START, so RUN adds the running one.
    assign occupied = queued_reg + CNT_W'(state_reg == RUN);
    assign free_cnt = N_CTX_C - occupied - CNT_W'(acquired_reg);
    assign acq_ok   = cfg_re_i && ctrl_sel && (ctrl_idx == 3'd1) && !acquired_reg
                      && (occupied < N_CTX_C);
    assign dispatch = (state_reg == IDLE) && (queued_reg != '0);
    assign finish   = (state_reg == RUN) && done_i;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (queued_reg != '0) state_next = START;
            START:   state_next = RUN;
            RUN:     if (done_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (clear) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            for (int c = 0; c < N_CONTEXT; c++) begin
                tag_mem[c] <= '0;
                for (int r = 0; r < N_REGS; r++) ctx_mem[c][r] <= '0;
            end
        end else begin
            if (reg_we) ctx_mem[wr_ptr_reg][reg_idx] <= cfg_wdata_i;
            if (acq_ok) tag_mem[wr_ptr_reg] <= job_id_reg;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            queued_reg     <= '0;
            acquired_reg   <= 1'b0;
            job_id_reg     <= '0;
            running_id_reg <= '0;
            finished_reg   <= '0;
            evt_reg        <= 1'b0;
            for (int r = 0; r < N_REGS; r++) cfg_reg[r] <= '0;
        end else begin
            if (acq_ok) begin
                acquired_reg <= 1'b1;
                job_id_reg   <= job_id_reg + ID_W'(1);
            end
            if (trigger) begin
                acquired_reg <= 1'b0;
                wr_ptr_reg   <= wr_ptr_reg + PTR_W'(1);
            end
            queued_reg <= queued_reg + CNT_W'(trigger) - CNT_W'(state_reg == START);
            if (dispatch) begin
                cfg_reg        <= ctx_mem[rd_ptr_reg];
                running_id_reg <= tag_mem[rd_ptr_reg];
            end
            if (finish) begin
                rd_ptr_reg   <= rd_ptr_reg + PTR_W'(1);
                finished_reg <= finished_reg + 32'd1;
            end
            evt_reg <= finish;
        end
    end

    assign start_o = (state_reg == START);
    assign busy_o  = (state_reg != IDLE);
    assign evt_o   = evt_reg;
    assign status  = {7'd0, acquired_reg, 8'(free_cnt), 8'(queued_reg), 7'd0, busy_o};

    always_comb begin
        cfg_rdata_o = '0;
        if (cfg_re_i) begin
            if (ctrl_sel) begin
                case (ctrl_idx)
                    3'd1:    cfg_rdata_o = acq_ok ? 32'(job_id_reg) : 32'hFFFF_FFFF;
                    3'd2:    cfg_rdata_o = finished_reg;
                    3'd3:    cfg_rdata_o = status;
                    3'd4:    cfg_rdata_o = 32'(running_id_reg);
                    default: cfg_rdata_o = '0;
                endcase
            end else if (acquired_reg && reg_in_range) begin
                cfg_rdata_o = ctx_mem[wr_ptr_reg][reg_idx];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_REGS; gi++) begin : gen_cfg
            assign cfg_o[gi*32 +: 32] = cfg_reg[gi];
        end
    endgenerate
endmodule

// File: tb/tb_redmule_job_ctrl.sv
// Randomized + directed bench for redmule_job_ctrl against a queue-based job model.
module tb_redmule_job_ctrl;
    localparam int NC = 2;
    localparam int NR = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_i = 1'b1, cfg_we_i = 1'b0, cfg_re_i = 1'b0, done_i = 1'b0;
    logic [7:0] cfg_addr_i = '0;
    logic [31:0] cfg_wdata_i = '0;
    logic [31:0] cfg_rdata_o;
    logic start_o, evt_o, busy_o;
    logic [NR*32-1:0] cfg_o;

    redmule_job_ctrl #(.N_CONTEXT(NC), .N_REGS(NR), .ID_W(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_we_i(cfg_we_i), .cfg_re_i(cfg_re_i),
        .cfg_addr_i(cfg_addr_i), .cfg_wdata_i(cfg_wdata_i), .cfg_rdata_o(cfg_rdata_o),
        .start_o(start_o), .cfg_o(cfg_o), .done_i(done_i), .evt_o(evt_o), .busy_o(busy_o)
    );

    int checks = 0, errors = 0;
    bit chk_en = 0;
    logic rst_drv = 1'b1;
    logic [31:0] dummy, r;
    logic seen_start, seen_evt;
    int seen_start_cyc;
    logic [NR*32-1:0] seen_cfg;

    // Behavioural model: queued jobs as (tag, config) FIFOs plus the job on the engine.
    int mcyc = 0;
    bit m_acq;
    int m_tag_acq, m_jobid, m_wr, m_eng_start, m_last_tag, m_evt_at;
    logic [31:0] m_fin;
    logic [31:0] m_mem [NC][NR];
    int q_tag[$];
    logic [NR*32-1:0] q_cfg[$];
    bit m_eng;
    logic [NR*32-1:0] m_cfg;

    function automatic bit exp_busy();
        return m_eng && (mcyc >= m_eng_start);
    endfunction

    function automatic logic [31:0] model_read(logic [7:0] a);
        int occ, qd, fr, idx;
        logic [31:0] v;
        occ = q_tag.size() + int'(m_eng);
        v = '0;
        if (a[7]) begin
            case (a[2:0])
                3'd1: v = (!m_acq && occ < NC) ? 32'(m_jobid) : 32'hFFFF_FFFF;
                3'd2: v = m_fin;
                3'd3: begin
                    qd = q_tag.size() + ((m_eng && mcyc == m_eng_start) ? 1 : 0);
                    fr = NC - occ - int'(m_acq);
                    v = {7'd0, m_acq, 8'(fr), 8'(qd), 7'd0, exp_busy()};
                end
                3'd4: v = 32'(m_last_tag);
                default: v = '0;
            endcase
        end else begin
            idx = int'(a[4:0]);
            if (m_acq && idx < NR) v = m_mem[m_wr][idx];
        end
        return v;
    endfunction

    task automatic model_step(input logic we, input logic re, input logic [7:0] a,
                              input logic [31:0] wd, input logic dn, input logic rs);
        bit acq_ok;
        int occ;
        logic [NR*32-1:0] pk;
        if (rs || (we && a[7] && a[2:0] == 3'd5)) begin
            m_acq = 0; m_jobid = 0; m_fin = '0; m_wr = 0; m_eng = 0; m_cfg = '0;
            m_last_tag = 0; m_evt_at = -1; m_eng_start = 0;
            q_tag.delete(); q_cfg.delete();
            for (int c = 0; c < NC; c++) for (int k = 0; k < NR; k++) m_mem[c][k] = '0;
        end else begin
            occ = q_tag.size() + int'(m_eng);
            acq_ok = re && a[7] && (a[2:0] == 3'd1) && !m_acq && (occ < NC);
            if (!m_eng && q_tag.size() > 0) begin
                m_eng = 1; m_eng_start = mcyc + 1;
                m_cfg = q_cfg.pop_front(); m_last_tag = q_tag.pop_front();
            end
            if (dn && m_eng && mcyc > m_eng_start) begin
                m_eng = 0; m_evt_at = mcyc + 1; m_fin = m_fin + 1;
            end
            if (we && !a[7] && int'(a[4:0]) < NR && m_acq) m_mem[m_wr][int'(a[4:0])] = wd;
            if (we && a[7] && a[2:0] == 3'd0 && m_acq) begin
                for (int k = 0; k < NR; k++) pk[k*32 +: 32] = m_mem[m_wr][k];
                q_cfg.push_back(pk); q_tag.push_back(m_tag_acq);
                m_wr = (m_wr + 1) % NC; m_acq = 0;
            end
            if (acq_ok) begin
                m_acq = 1; m_tag_acq = m_jobid; m_jobid = (m_jobid + 1) % 256;
            end
        end
        mcyc++;
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, mcyc, act, exp);
        end
    endtask

    task automatic chk_cfg(input logic [NR*32-1:0] act, input logic [NR*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg_o cyc=%0d got=%h want=%h", mcyc, act, exp);
        end
    endtask

    // One clock cycle: check this cycle's outputs, drive inputs, check read data, advance model.
    task automatic tick(input logic we, input logic re, input logic [7:0] a,
                        input logic [31:0] wd, input logic dn, output logic [31:0] rd);
        @(negedge clk);
        if (chk_en) begin
            chk32("start_o", 32'(start_o), 32'(m_eng && mcyc == m_eng_start));
            chk32("busy_o", 32'(busy_o), 32'(exp_busy()));
            chk32("evt_o", 32'(evt_o), 32'(mcyc == m_evt_at));
            chk_cfg(cfg_o, m_cfg);
        end
        seen_start = start_o; seen_evt = evt_o; seen_cfg = cfg_o;
        if (start_o) seen_start_cyc = mcyc;
        if (chk_en && evt_o) $display("job complete event at cycle %0d, finished=%0d", mcyc, m_fin);
        rst_i = rst_drv; cfg_we_i = we; cfg_re_i = re; cfg_addr_i = a;
        cfg_wdata_i = wd; done_i = dn;
        #1;
        rd = cfg_rdata_o;
        if (chk_en && re) chk32("cfg_rdata", rd, model_read(a));
        model_step(we, re, a, wd, dn, rst_drv);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 8'h00, '0, 0, dummy);
    endtask
    task automatic acquire(output logic [31:0] id);
        tick(0, 1, 8'h81, '0, 0, id);
    endtask
    task automatic trigger();
        tick(1, 0, 8'h80, '0, 0, dummy);
    endtask
    task automatic reg_wr(input int i, input logic [31:0] v);
        tick(1, 0, 8'(i), v, 0, dummy);
    endtask
    task automatic ctrl_rd(input int i, output logic [31:0] v);
        tick(0, 1, 8'h80 | 8'(i), '0, 0, v);
    endtask
    task automatic soft_clear();
        tick(1, 0, 8'h85, '0, 0, dummy);
    endtask
    task automatic pulse_done();
        tick(0, 0, 8'h00, '0, 1, dummy);
    endtask
    task automatic wait_start(input int budget);
        int n;
        n = 0;
        do begin
            idle(1);
            n++;
        end while (!seen_start && n < budget);
        chk32("wait_start", 32'(seen_start), 32'd1);
    endtask

    initial begin
        int t0;
        bit any_evt;
        logic [7:0] a;
        logic we, re, dn;
        int op;

        // Reset
        tick(0, 0, 8'h00, '0, 0, dummy);
        chk_en = 1;
        tick(0, 0, 8'h00, '0, 0, dummy);
        rst_drv = 1'b0;
        idle(2);
        ctrl_rd(3, r); chk32("status_reset", r, 32'h0002_0000);
        ctrl_rd(2, r); chk32("finished_reset", r, 32'h0);
        ctrl_rd(4, r); chk32("running_id_reset", r, 32'h0);

        // Single job
        acquire(r); chk32("acq_job0", r, 32'h0);
        reg_wr(0, 32'h1000); reg_wr(5, 32'h0400);
        ctrl_rd(3, r); chk32("status_acquired", r, 32'h0101_0000);
        t0 = mcyc;
        trigger();
        wait_start(10);
        chk32("start_latency", 32'(seen_start_cyc - t0), 32'd2);
        chk32("job0_word0", seen_cfg[31:0], 32'h1000);
        chk32("job0_word5", seen_cfg[5*32 +: 32], 32'h0400);
        idle(19);
        pulse_done();
        idle(1);
        chk32("evt_after_done", 32'(seen_evt), 32'd1);
        ctrl_rd(2, r); chk32("finished_one", r, 32'd1);

        // Double acquire and orphan trigger
        acquire(r); chk32("acq_job1", r, 32'd1);
        acquire(r); chk32("double_acquire", r, 32'hFFFF_FFFF);
        trigger(); wait_start(10); idle(3); pulse_done(); idle(2);
        trigger(); idle(4);
        ctrl_rd(3, r); chk32("orphan_status", r, 32'h0002_0000);

        // Queue full and isolation
        acquire(r); chk32("acq_job2", r, 32'd2);
        reg_wr(0, 32'hAAAA); trigger(); wait_start(10);
        acquire(r); chk32("acq_job3", r, 32'd3);
        reg_wr(0, 32'hDEAD); idle(1);
        chk32("isolation_word0", seen_cfg[31:0], 32'hAAAA);
        trigger();
        acquire(r); chk32("acq_full", r, 32'hFFFF_FFFF);
        ctrl_rd(4, r); chk32("running_id_2", r, 32'd2);
        tick(0, 1, 8'h81, '0, 1, r); chk32("acq_with_done", r, 32'hFFFF_FFFF);
        acquire(r); chk32("acq_retry", r, 32'd4);
        wait_start(10);
        chk32("job3_word0", seen_cfg[31:0], 32'hDEAD);
        ctrl_rd(4, r); chk32("running_id_3", r, 32'd3);
        trigger(); idle(3); pulse_done(); wait_start(10); idle(2); pulse_done(); idle(2);

        // Soft clear mid-run
        acquire(r); chk32("acq_job5", r, 32'd5);
        trigger(); wait_start(10); idle(3);
        soft_clear();
        any_evt = 0;
        for (int i = 0; i < 8; i++) begin
            tick(0, 0, 8'h00, '0, (i == 2), dummy);
            if (seen_evt) any_evt = 1;
        end
        chk32("no_evt_after_clear", 32'(any_evt), 32'd0);
        ctrl_rd(3, r); chk32("status_after_clear", r, 32'h0002_0000);
        acquire(r); chk32("acq_after_clear", r, 32'h0);
        trigger(); wait_start(10); idle(1); pulse_done(); idle(2);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            op = $urandom_range(0, 99);
            we = 0; re = 0; a = 8'h00;
            dn = ($urandom_range(0, 4) == 0);
            if (op < 15)      begin re = 1; a = 8'h81; end
            else if (op < 30) begin we = 1; a = 8'h80; end
            else if (op < 55) begin we = 1; re = ($urandom_range(0, 2) == 0); a = 8'($urandom_range(0, 23)); end
            else if (op < 70) begin re = 1; a = 8'($urandom_range(0, 31)); end
            else if (op < 85) begin re = 1; a = 8'h80 | 8'($urandom_range(0, 7)); end
            else if (op < 87) begin we = 1; a = 8'h80 | 8'($urandom_range(1, 4)); end
            else if (op < 88) begin we = 1; a = 8'h85; end
            tick(we, re, a, $urandom, dn, dummy);
        end

        // Job-ID wrap
        soft_clear();
        for (int i = 0; i < 257; i++) begin
            acquire(r); chk32("wrap_id", r, 32'(i % 256));
            trigger(); wait_start(10); idle(1); pulse_done(); idle(1);
        end
        ctrl_rd(2, r); chk32("finished_257", r, 32'd257);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/redmule_job_ctrl.md
Name: redmule_job_ctrl

Overview:
- Job/context controller in front of the RedMulE scheduler.
- Holds N_CONTEXT shadow copies of the REDMULE_REGS-word configuration register file. Software acquires a context, programs it, and triggers it.
- Dispatches queued contexts to the engine in FIFO order using a start/done handshake, and raises a completion event per job.
- Sits between the peripheral config slave and the engine/scheduler configuration inputs.

Parameters:
- N_CONTEXT, 2, number of job contexts; power of two, ≥2.
- N_REGS, 22, 32-bit config words per context.
- ID_W, 8, job-ID counter width; ≤31.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- cfg_we_i  in  1  write strobe.
- cfg_re_i  in  1  read strobe.
- cfg_addr_i  in  8  word address. [7]=0: context-register space, index [4:0]. [7]=1: control space, index [2:0].
- cfg_wdata_i  in  32  write data.
- cfg_rdata_o  out  32  read data, combinational, valid in the cycle of cfg_re_i.
- start_o  out  1  one-cycle engine start pulse.
- cfg_o  out  N_REGS*32  configuration of the dispatched context.
- done_i  in  1  engine completion pulse.
- evt_o  out  1  one-cycle job-complete event.
- busy_o  out  1  engine running (state START or RUN).

Behaviour:
- Reset: every context FREE, all words 0. wr_ptr=rd_ptr=0, queued=0, acquired=0, job_id=0, finished=0. State IDLE. start_o=evt_o=busy_o=0, cfg_o=0.
- Context life cycle: FREE -> ACQUIRED -> QUEUED -> RUNNING -> FREE.
  - At most one context is ACQUIRED at a time, always the one at wr_ptr.
- Control space, reads:
  - 1 ACQUIRE.
    - Succeeds when no context is acquired and (queued + running) < N_CONTEXT.
    - On success: returns job_id zero-extended, marks ctx[wr_ptr] ACQUIRED, tags it with job_id, increments job_id (wraps at 2^ID_W).
    - On failure: returns 0xFFFFFFFF with no state change.
  - 2 FINISHED: returns the completed-job counter (32-bit, wraps).
  - 3 STATUS: [0]=busy_o, [15:8]=queued, [23:16]=free count, [24]=acquired.
  - 4 RUNNING_ID: tag of the last dispatched job; 0 before the first dispatch.
  - Other control indices read 0.
- Control space, writes:
  - 0 TRIGGER. If a context is acquired: it becomes QUEUED, wr_ptr++ (mod N_CONTEXT), queued++. Otherwise ignored.
  - 5 SOFT_CLEAR. Same effect as reset on the next edge, including an in-flight job. done_i for the aborted job is ignored.
  - Other control indices and data ignored.
- Register space:
  - Write index < N_REGS: stores into ctx[wr_ptr] only if acquired; otherwise ignored.
  - Read: returns ctx[wr_ptr][index] if acquired and index < N_REGS, else 0.
  - QUEUED/RUNNING contexts are never modified.
- Dispatch FSM:
  - IDLE: if queued>0 -> START. cfg_o is loaded from ctx[rd_ptr] on this edge.
  - START: start_o=1 for exactly one cycle -> RUN. queued--.
  - RUN: on done_i -> IDLE. Same edge: ctx[rd_ptr] -> FREE, rd_ptr++, finished++, evt_o=1 next cycle (one cycle).
  - done_i outside RUN is ignored.
- Latency:
  - TRIGGER write in cycle 0 -> start_o high in cycle 2 when IDLE.
  - done_i in cycle n -> evt_o in cycle n+1. A next queued job gets start_o in cycle n+2.
- cfg_o is stable from START until the next dispatch. It is unaffected by register-space writes.
- Simultaneous events:
  - TRIGGER together with IDLE→START: the new job is counted and dispatched afterwards; FIFO order is preserved.
  - ACQUIRE in the same cycle as done_i uses pre-edge occupancy (conservative). A retry one cycle later succeeds.
  - cfg_we_i and cfg_re_i together: both are honoured. Read data reflects pre-edge state.
  - SOFT_CLEAR has priority over every other event in the same cycle.
- Reset or SOFT_CLEAR mid-RUN: start_o/evt_o/busy_o drop to 0 after the edge. No evt_o is emitted for the aborted job.

Test Plan:
- Single job:
  - Stimulus: ACQUIRE (returns 0); write word0=0x1000, word5=0x0400; TRIGGER in cycle 10.
  - Required: start_o in cycle 12 with cfg_o word0=0x1000, word5=0x0400. busy_o=1 until done_i, which is driven 20 cycles later. evt_o one cycle after done_i. FINISHED=1.
- Queue full (N_CONTEXT=2):
  - Stimulus: acquire/trigger IDs 0 and 1 while the engine holds RUN; third ACQUIRE.
  - Required: third ACQUIRE returns 0xFFFFFFFF. After done_i it returns 2. Jobs dispatch in ID order 0, 1. RUNNING_ID follows.
- Double acquire / orphan trigger:
  - ACQUIRE then ACQUIRE with no TRIGGER -> second returns 0xFFFFFFFF.
  - TRIGGER with nothing acquired -> STATUS queued stays 0, no start_o.
- Isolation:
  - Stimulus: while job 0 runs, acquire job 1 and write word0=0xDEAD.
  - Required: cfg_o word0 of job 0 unchanged. Job 1 dispatch shows 0xDEAD.
- ID wrap (ID_W=8):
  - Stimulus: 257 acquire/trigger/done cycles.
  - Required: IDs 0..255, then 0. FINISHED=257.
- SOFT_CLEAR mid-RUN:
  - Stimulus: SOFT_CLEAR during RUN, then done_i.
  - Required: no evt_o. STATUS=0x00000000 except free=N_CONTEXT. Next ACQUIRE returns 0.
